// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V pipeline definitions: architectural widths,
//               default reset vector, canonical NOP encoding and the
//               fetch-queue entry layout {addr, instr}.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR            = 32'h0000_0013;

    // One buffered fetch: PC in the upper field, instruction word below it.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry synchronous FIFO holding fetched
//               {address, instruction} pairs. Flush empties the queue and
//               takes priority over push and pop in the same cycle.
// Ports       : i_clock      - clock, rising edge
//               i_reset      - asynchronous active-high reset
//               i_push       - write i_push_data at the tail
//               i_push_data  - entry to write
//               i_pop        - remove the head entry
//               i_flush      - discard every entry
//               o_head       - head entry (meaningful when o_empty = 0)
//               o_count      - occupancy, 0..DEPTH
//               o_empty      - queue holds no entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == c_cnt_w'(DEPTH));
    assign w_do_pop  = i_pop & (r_count != '0);
    // A push into a full queue is only accepted if the head leaves this cycle,
    // so an entry can never be overwritten.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible after it was written.
    always_ff @(posedge i_clock) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue
// Description : Buffered instruction-fetch stage. Issues sequential PCs to a
//               1-cycle-latency instruction memory, queues the returned
//               {PC, instruction} pairs and hands them to decode through a
//               valid/ready handshake. A redirect flushes the queue, squashes
//               the in-flight response and fetches the new target at once.
// Ports       : i_clock         - clock, rising edge
//               i_reset         - asynchronous active-high reset
//               o_imem_req      - instruction memory read request
//               o_imem_addr     - word-aligned request address
//               i_imem_rdata    - instruction, one cycle after the request
//               i_redirect      - taken branch/jump
//               i_redirect_addr - redirect target (bits [1:0] ignored)
//               o_valid         - queue head holds an instruction
//               i_ready         - decode accepts the head
//               o_address       - PC of the head instruction
//               o_instruccion   - head instruction word
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int unsigned     XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(riscv_pkg::RESET_VECTOR_DEFAULT),
    parameter int unsigned     DEPTH        = 4
) (
    input  logic            i_clock,
    input  logic            i_reset,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [31:0]     i_imem_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_addr,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_address,
    output logic [31:0]     o_instruccion
);

    import riscv_pkg::*;

    localparam int unsigned     c_cnt_w      = $clog2(DEPTH+1);
    localparam int unsigned     c_entry_w    = XLEN + ILEN;
    localparam logic [XLEN-1:0] c_align_mask = ~XLEN'(3);
    localparam logic [XLEN-1:0] c_pc_step    = XLEN'(4);

    logic [XLEN-1:0]      r_pc;
    logic                 r_inflight;
    logic [XLEN-1:0]      r_inflight_pc;

    logic [XLEN-1:0]      w_target;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_issue;
    logic [c_cnt_w:0]     w_occupancy;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_empty;
    logic [c_entry_w-1:0] w_head;

    assign w_target = i_redirect_addr & c_align_mask;

    // A redirect discards the head, so a simultaneous handshake is not a pop.
    assign w_pop = o_valid & i_ready & ~i_redirect;

    // The response arriving during a redirect belongs to the old path.
    assign w_push = r_inflight & ~i_redirect;

    // Slots already promised (queued + in flight) minus the one leaving now.
    // Never negative: a pop implies at least one queued entry.
    assign w_occupancy = {1'b0, w_count}
                       + {{c_cnt_w{1'b0}}, r_inflight}
                       - {{c_cnt_w{1'b0}}, w_pop};

    // A redirect always issues: the queue is flushed and the in-flight
    // response squashed, so a slot is guaranteed. Reset gates the request
    // combinationally so it drops immediately on async assertion.
    assign w_issue = ~i_reset
                   & (i_redirect | (w_occupancy < (c_cnt_w+1)'(DEPTH)));

    assign o_imem_req  = w_issue;
    assign o_imem_addr = i_redirect ? w_target : r_pc;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pc          <= RESET_VECTOR;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= o_imem_addr;
                r_pc          <= o_imem_addr + c_pc_step;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fetch_fifo (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data ({r_inflight_pc, i_imem_rdata}),
        .i_pop       (w_pop),
        .i_flush     (i_redirect),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    assign o_valid       = ~w_empty;
    // Zero the head fields when nothing is queued (including during reset).
    assign o_address     = o_valid ? w_head[c_entry_w-1:ILEN] : '0;
    assign o_instruccion = o_valid ? w_head[ILEN-1:0]         : '0;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_queue
// Description : Directed self-checking bench for if_fetch_queue. The memory
//               model answers every request one cycle later with
//               address ^ 32'hA5A5_0000. A second instance uses a reset
//               vector near the top of the address space to exercise wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    localparam logic [31:0] c_key = 32'hA5A5_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_VECTOR = 0, DEPTH = 4)
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        valid;
    logic        ready = 1'b1;
    logic [31:0] address;
    logic [31:0] instr;

    // Wrap instance (RESET_VECTOR = 0xFFFF_FFF8)
    logic        rst_w = 1'b1;
    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_rdata_w = 32'h0;
    logic        redirect_w = 1'b0;
    logic [31:0] redirect_addr_w = 32'h0;
    logic        valid_w;
    logic        ready_w = 1'b1;
    logic [31:0] address_w;
    logic [31:0] instr_w;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_queue #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .DEPTH(4)
    ) dut (
        .i_clock(clk), .i_reset(rst),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
        .i_redirect(redirect), .i_redirect_addr(redirect_addr),
        .o_valid(valid), .i_ready(ready),
        .o_address(address), .o_instruccion(instr)
    );

    if_fetch_queue #(
        .XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .DEPTH(4)
    ) dut_wrap (
        .i_clock(clk), .i_reset(rst_w),
        .o_imem_req(imem_req_w), .o_imem_addr(imem_addr_w), .i_imem_rdata(imem_rdata_w),
        .i_redirect(redirect_w), .i_redirect_addr(redirect_addr_w),
        .o_valid(valid_w), .i_ready(ready_w),
        .o_address(address_w), .o_instruccion(instr_w)
    );

    // Synchronous instruction memory, 1-cycle read latency.
    always @(posedge clk) begin
        if (imem_req)   imem_rdata   <= imem_addr ^ c_key;
        if (imem_req_w) imem_rdata_w <= imem_addr_w ^ c_key;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Holds reset across two edges and releases it mid-cycle: the caller
    // returns in cycle 0 (the first cycle that ends with an active edge).
    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        redirect_addr = 32'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_checks++;
        if (address !== 32'h0) begin n_fail++; $display("FAIL reset_address: got %h expected 00000000", address); end
        n_checks++;
        if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    endtask

    task automatic test_sequential();
        ready = 1'b1;
        do_reset();
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL seq_cycle0_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
        end
        step();
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL seq_cycle1_valid: got %b expected 0", valid); end
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++;
            if (valid !== 1'b1 || address !== 32'(4*k) || instr !== (32'(4*k) ^ c_key)) begin
                n_fail++;
                $display("FAIL seq_head%0d: got valid=%b addr=%h instr=%h expected valid=1 addr=%h instr=%h",
                         k, valid, address, instr, 32'(4*k), 32'(4*k) ^ c_key);
            end
        end
    endtask

    task automatic test_backpressure();
        int n_req;
        n_req = 0;
        ready = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            #1;
            if (imem_req === 1'b1) begin
                n_checks++;
                if (imem_addr !== 32'(4*n_req)) begin
                    n_fail++; $display("FAIL bp_req_addr: got %h expected %h", imem_addr, 32'(4*n_req));
                end
                n_req++;
            end
        end
        n_checks++;
        if (n_req != 4) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 4", n_req); end
        n_checks++;
        if (valid !== 1'b1 || address !== 32'h0) begin
            n_fail++; $display("FAIL bp_full_head: got valid=%b addr=%h expected valid=1 addr=00000000", valid, address);
        end
        step();
        ready = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            n_fail++; $display("FAIL bp_resume_req: got req=%b addr=%h expected req=1 addr=00000010", imem_req, imem_addr);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            n_checks++;
            if (valid !== 1'b1 || address !== 32'(4*k) || instr !== (32'(4*k) ^ c_key)) begin
                n_fail++;
                $display("FAIL bp_drain%0d: got valid=%b addr=%h instr=%h expected valid=1 addr=%h",
                         k, valid, address, instr, 32'(4*k));
            end
        end
    endtask

    task automatic test_redirect();
        ready = 1'b1;
        do_reset();
        for (int c = 0; c < 5; c++) step();
        n_checks++;
        if (valid !== 1'b1 || address !== 32'hC) begin
            n_fail++; $display("FAIL redir_pre_head: got valid=%b addr=%h expected valid=1 addr=0000000c", valid, address);
        end
        redirect = 1'b1;
        redirect_addr = 32'h1003;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin
            n_fail++; $display("FAIL redir_req: got req=%b addr=%h expected req=1 addr=00001000", imem_req, imem_addr);
        end
        step();
        redirect = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL redir_t1_valid: got %b expected 0", valid); end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h1004) begin
            n_fail++; $display("FAIL redir_t1_req: got req=%b addr=%h expected req=1 addr=00001004", imem_req, imem_addr);
        end
        step();
        n_checks++;
        if (valid !== 1'b1 || address !== 32'h1000 || instr !== 32'hA5A5_1000) begin
            n_fail++; $display("FAIL redir_t2_head: got valid=%b addr=%h instr=%h expected valid=1 addr=00001000 instr=a5a51000", valid, address, instr);
        end
        step();
        n_checks++;
        if (valid !== 1'b1 || address !== 32'h1004 || instr !== 32'hA5A5_1004) begin
            n_fail++; $display("FAIL redir_t3_head: got valid=%b addr=%h instr=%h expected valid=1 addr=00001004 instr=a5a51004", valid, address, instr);
        end
    endtask

    task automatic test_back_to_back();
        ready = 1'b1;
        do_reset();
        for (int c = 0; c < 3; c++) step();
        n_checks++;
        if (valid !== 1'b1 || address !== 32'h4) begin
            n_fail++; $display("FAIL b2b_pre_head: got valid=%b addr=%h expected valid=1 addr=00000004", valid, address);
        end
        redirect = 1'b1;
        redirect_addr = 32'h3000;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
            n_fail++; $display("FAIL b2b_req1: got req=%b addr=%h expected req=1 addr=00003000", imem_req, imem_addr);
        end
        step();
        redirect_addr = 32'h2000;
        #1;
        n_checks++;
        if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
            n_fail++; $display("FAIL b2b_req2: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00002000", valid, imem_req, imem_addr);
        end
        step();
        redirect = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_valid: got %b expected 0", valid); end
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (valid !== 1'b1 || address !== (32'h2000 + 32'(4*k)) || instr !== ((32'h2000 + 32'(4*k)) ^ c_key)) begin
                n_fail++;
                $display("FAIL b2b_head%0d: got valid=%b addr=%h instr=%h expected valid=1 addr=%h",
                         k, valid, address, instr, 32'h2000 + 32'(4*k));
            end
        end
    endtask

    task automatic test_wrap();
        step();
        rst_w = 1'b0;
        #1;
        n_checks++;
        if (imem_req_w !== 1'b1 || imem_addr_w !== 32'hFFFF_FFF8) begin
            n_fail++; $display("FAIL wrap_req: got req=%b addr=%h expected req=1 addr=fffffff8", imem_req_w, imem_addr_w);
        end
        step();
        step();
        n_checks++;
        if (valid_w !== 1'b1 || address_w !== 32'hFFFF_FFF8 || instr_w !== 32'h5A5A_FFF8) begin
            n_fail++; $display("FAIL wrap_head0: got valid=%b addr=%h instr=%h expected valid=1 addr=fffffff8 instr=5a5afff8", valid_w, address_w, instr_w);
        end
        step();
        n_checks++;
        if (valid_w !== 1'b1 || address_w !== 32'hFFFF_FFFC || instr_w !== 32'h5A5A_FFFC) begin
            n_fail++; $display("FAIL wrap_head1: got valid=%b addr=%h instr=%h expected valid=1 addr=fffffffc instr=5a5afffc", valid_w, address_w, instr_w);
        end
        step();
        n_checks++;
        if (valid_w !== 1'b1 || address_w !== 32'h0 || instr_w !== 32'hA5A5_0000) begin
            n_fail++; $display("FAIL wrap_head2: got valid=%b addr=%h instr=%h expected valid=1 addr=00000000 instr=a5a50000", valid_w, address_w, instr_w);
        end
    endtask

    task automatic test_async_reset();
        ready = 1'b0;
        do_reset();
        for (int c = 0; c < 6; c++) step();
        n_checks++;
        if (valid !== 1'b1 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL areset_full: got valid=%b req=%b expected valid=1 req=0", valid, imem_req);
        end
        ready = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL areset_pre_req: got %b expected 1", imem_req); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (valid !== 1'b0 || imem_req !== 1'b0 || address !== 32'h0) begin
            n_fail++; $display("FAIL areset_immediate: got valid=%b req=%b addr=%h expected valid=0 req=0 addr=00000000", valid, imem_req, address);
        end
        step();
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL areset_restart_req: got req=%b addr=%h valid=%b expected req=1 addr=00000000 valid=0", imem_req, imem_addr, valid);
        end
        step();
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL areset_cycle1_valid: got %b expected 0", valid); end
        step();
        n_checks++;
        if (valid !== 1'b1 || address !== 32'h0 || instr !== c_key) begin
            n_fail++; $display("FAIL areset_cycle2_head: got valid=%b addr=%h instr=%h expected valid=1 addr=00000000 instr=a5a50000", valid, address, instr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
